// File: rtl/nv_nvdla_mcif_wr_pkg.sv
// Shared types for the MCIF write outstanding-beat tracker.
// Holds the per-client completion-queue entry and counter widths.
// Used by nv_nvdla_mcif_wr_ostrack and nv_nvdla_mcif_wr_ostrack_fifo.
package nv_nvdla_mcif_wr_pkg;

  localparam int LEN_W    = 2;
  localparam int OS_CNT_W = 9;

  // One issued AXI write: beats-minus-one and end-of-DMA-request marker.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             last;
  } cq_entry_t;

  // Beat count of a transaction from its beats-minus-one length.
  function automatic logic [OS_CNT_W-1:0] beats(input logic [LEN_W-1:0] len);
    return OS_CNT_W'(len) + OS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_wr_ostrack_fifo.sv
// Purpose: flop-based in-order completion queue for one write client.
// Latency: push visible at head next cycle; head is a combinational read.
// Backpressure: full/empty flags only; caller never pushes when full or pops when empty.
// Ports: clk/rst_n, push + push_dat, pop, head_dat, full, empty.
module nv_nvdla_mcif_wr_ostrack_fifo
  import nv_nvdla_mcif_wr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  cq_entry_t push_dat,
  input  logic      pop,
  output cq_entry_t head_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  cq_entry_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/nv_nvdla_mcif_wr_ostrack.sv
// Purpose: tracks outstanding AXI write beats against a programmable limit and
//          turns in-order B responses into per-client DMA completion pulses.
// Latency: issue/response update os_beat_cnt next cycle; completion pulse one cycle after B.
// Backpressure: aw_issue_rdy drops when the beat limit or the client queue is full; B always accepted.
// Ports: nvdla_core_clk/nvdla_core_rstn, reg2dp_wr_os_cnt, aw_issue_* (vld/rdy/cid/len/last),
//        noc2mcif_axi_b_* (bvalid/bready/bid), mcif2client_wr_rsp_complete, os_beat_cnt, wr_rsp_err.
// Optional: NVDLA_MCIF_WR_OSTRACK_ERR_EN enables the sticky wr_rsp_err flag for stray B responses.
module nv_nvdla_mcif_wr_ostrack
  import nv_nvdla_mcif_wr_pkg::*;
#(
  parameter  int NUM_CLIENT = 5,
  parameter  int CQ_DEPTH   = 16,
  parameter  int ID_W       = 8,
  localparam int CID_W      = (NUM_CLIENT > 1) ? $clog2(NUM_CLIENT) : 1
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [7:0]            reg2dp_wr_os_cnt,
  input  logic                  aw_issue_vld,
  output logic                  aw_issue_rdy,
  input  logic [CID_W-1:0]      aw_issue_cid,
  input  logic [LEN_W-1:0]      aw_issue_len,
  input  logic                  aw_issue_last,
  input  logic                  noc2mcif_axi_b_bvalid,
  output logic                  noc2mcif_axi_b_bready,
  input  logic [ID_W-1:0]       noc2mcif_axi_b_bid,
  output logic [NUM_CLIENT-1:0] mcif2client_wr_rsp_complete,
  output logic [OS_CNT_W-1:0]   os_beat_cnt,
  output logic                  wr_rsp_err
);

  // Client indices decode to a power-of-two slot space; slots with no client
  // read as full and empty so issues to them stall and responses miss.
  localparam int NSLOT = 1 << CID_W;

  logic [NSLOT-1:0]      q_full;
  logic [NSLOT-1:0]      q_empty;
  cq_entry_t             q_head [NSLOT];
  logic [OS_CNT_W-1:0]   os_q;
  logic [NUM_CLIENT-1:0] complete_q;
  logic                  bready_q;
  logic [OS_CNT_W-1:0]   limit;
  logic [OS_CNT_W:0]     need;
  logic                  issue_fire;
  logic                  rsp_fire;
  logic [CID_W-1:0]      b_cid;
  logic                  b_in_range;
  logic                  pop_hit;
  cq_entry_t             pop_dat;
  cq_entry_t             push_dat;
  logic                  unused_bid;

  assign b_cid      = noc2mcif_axi_b_bid[CID_W-1:0];
  assign unused_bid = ^noc2mcif_axi_b_bid;

  // Limit is programmed minus one so that 0..255 covers 1..256 beats.
  assign limit = {1'b0, reg2dp_wr_os_cnt} + OS_CNT_W'(1);
  // One extra bit keeps os+len+1 from wrapping when the count sits at 256.
  assign need  = {1'b0, os_q} + (OS_CNT_W+1)'(aw_issue_len) + (OS_CNT_W+1)'(1);

  // Queue fullness is taken before any same-cycle pop, keeping rdy off the B path.
  assign aw_issue_rdy = (need <= {1'b0, limit}) && !q_full[aw_issue_cid];
  assign issue_fire   = aw_issue_vld && aw_issue_rdy;

  assign rsp_fire   = noc2mcif_axi_b_bvalid && bready_q;
  assign b_in_range = ({1'b0, b_cid} < (CID_W+1)'(NUM_CLIENT));
  assign pop_hit    = rsp_fire && b_in_range && !q_empty[b_cid];
  assign pop_dat    = q_head[b_cid];
  assign push_dat   = '{len: aw_issue_len, last: aw_issue_last};

  for (genvar g = 0; g < NSLOT; g++) begin : g_q
    if (g < NUM_CLIENT) begin : g_used
      logic q_push;
      logic q_pop;
      assign q_push = issue_fire && (aw_issue_cid == CID_W'(g));
      assign q_pop  = pop_hit && (b_cid == CID_W'(g));
      nv_nvdla_mcif_wr_ostrack_fifo #(.DEPTH(CQ_DEPTH)) u_cq (
        .clk      (nvdla_core_clk),
        .rst_n    (nvdla_core_rstn),
        .push     (q_push),
        .push_dat (push_dat),
        .pop      (q_pop),
        .head_dat (q_head[g]),
        .full     (q_full[g]),
        .empty    (q_empty[g])
      );
    end else begin : g_pad
      assign q_full[g]  = 1'b1;
      assign q_empty[g] = 1'b1;
      assign q_head[g]  = '0;
    end
  end

  // Net delta in one cycle; admission and hit guarantee 0 <= result <= limit.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      os_q       <= '0;
      complete_q <= '0;
      bready_q   <= 1'b0;
    end else begin
      os_q       <= os_q + (issue_fire ? beats(aw_issue_len) : '0)
                         - (pop_hit    ? beats(pop_dat.len)  : '0);
      complete_q <= (pop_hit && pop_dat.last) ? (NUM_CLIENT'(1) << b_cid) : '0;
      bready_q   <= 1'b1;
    end
  end

`ifdef NVDLA_MCIF_WR_OSTRACK_ERR_EN
  logic err_q;
  // Any accepted B that matches no outstanding entry is a protocol error.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)          err_q <= 1'b0;
    else if (rsp_fire && !pop_hit) err_q <= 1'b1;
  end
  assign wr_rsp_err = err_q;
`else
  assign wr_rsp_err = 1'b0;
`endif

  assign noc2mcif_axi_b_bready       = bready_q;
  assign mcif2client_wr_rsp_complete = complete_q;
  assign os_beat_cnt                 = os_q;

endmodule

// File: doc/nv_nvdla_mcif_wr_ostrack.md
NV_NVDLA_MCIF_WR_OSTRACK -- requirements
Module: nv_nvdla_mcif_wr_ostrack

Interface
REQ-001 Parameter NUM_CLIENT, 5, number of write-DMA clients (1..8).
REQ-002 Parameter CQ_DEPTH, 16, entries per client completion queue (power of 2, 2..64).
REQ-003 Parameter ID_W, 8, AXI AW/B ID width; client index = bid[CID_W-1:0], where CID_W = clog2(NUM_CLIENT), minimum 1.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: nvdla_core_clk  in  1  core clock.
REQ-006 Port: nvdla_core_rstn  in  1  async active-low reset.
REQ-007 Port: reg2dp_wr_os_cnt  in  8  outstanding-beat limit minus one.
REQ-008 Port: aw_issue_vld  in  1  AW transaction about to issue.
REQ-009 Port: aw_issue_rdy  out  1  tracker accepts issue.
REQ-010 Port: aw_issue_cid  in  CID_W  issuing client.
REQ-011 Port: aw_issue_len  in  2  beats minus one (1..4 beats).
REQ-012 Port: aw_issue_last  in  1  final AXI transaction of a DMA request.
REQ-013 Port: noc2mcif_axi_b_bvalid  in  1  write response valid.
REQ-014 Port: noc2mcif_axi_b_bready  out  1  write response ready.
REQ-015 Port: noc2mcif_axi_b_bid  in  ID_W  response ID.
REQ-016 Port: mcif2client_wr_rsp_complete  out  NUM_CLIENT  per-client one-cycle completion pulse.
REQ-017 Port: os_beat_cnt  out  9  current outstanding beats.
REQ-018 Port: wr_rsp_err  out  1  sticky protocol error (see REQ-031).

Function
REQ-019 Limit L SHALL be reg2dp_wr_os_cnt+1, computed at 9 bits (range 1..256).
REQ-020 aw_issue_rdy SHALL be 1 iff os_beat_cnt+aw_issue_len+1 <= L and the aw_issue_cid queue count (before any same-cycle pop) < CQ_DEPTH; rdy is combinational from registered state and current inputs.
REQ-021 On vld&rdy, {aw_issue_len, aw_issue_last} SHALL be pushed to the client queue and os_beat_cnt SHALL increase by len+1 in the next cycle.
REQ-022 noc2mcif_axi_b_bready SHALL be constant 1 out of reset.
REQ-023 On bvalid, when the addressed client index < NUM_CLIENT and its queue is non-empty, the head SHALL be popped and os_beat_cnt decremented by head.len+1.
REQ-024 Simultaneous issue and response SHALL update os_beat_cnt by the net delta in one cycle; the limit check uses the pre-update count.
REQ-025 Popped entry with last=1 SHALL assert mcif2client_wr_rsp_complete[cid] for exactly one cycle, one cycle after the B handshake (registered).
REQ-026 Per-client queues SHALL be in-order and independent; push and pop on the same client in one cycle are both honoured.
REQ-027 Lowering reg2dp_wr_os_cnt below os_beat_cnt SHALL only hold rdy low until drained; no counter change.
REQ-028 os_beat_cnt SHALL never exceed 256 nor underflow.

Reset
REQ-029 During reset: os_beat_cnt=0, all queues empty, complete=0, wr_rsp_err=0, aw_issue_rdy evaluates with zero state; bready=0 while nvdla_core_rstn low.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding entries with no completion pulses.

Configuration
REQ-031 With NVDLA_MCIF_WR_OSTRACK_ERR_EN defined: a B response to an empty queue or client index >= NUM_CLIENT SHALL set wr_rsp_err (sticky until reset) and change no other state.
REQ-032 Without NVDLA_MCIF_WR_OSTRACK_ERR_EN: wr_rsp_err tied 0; such responses are silently dropped.

Structure
REQ-033 Package nv_nvdla_mcif_wr_pkg SHALL hold the queue-entry typedef {len[1:0], last}, LEN_W=2, OS_CNT_W=9.
REQ-034 Sub-module nv_nvdla_mcif_wr_ostrack_fifo (flop-based, CQ_DEPTH deep, one per client, generate loop) SHALL implement each queue.

Verification
REQ-035 os_cnt=7 (L=8): issue cid0 len=3 twice -> rdy 1,1; third len=0 -> rdy=0; os_beat_cnt=8.
REQ-036 cid2 issues len=1 last=0, then len=0 last=1; B bid=2 twice -> complete[2] pulses only after second B, one cycle later; os_beat_cnt 3->1->0.
REQ-037 Same cycle: issue cid1 len=3 and B for cid0 head len=1 at os=6 -> os_beat_cnt=8.
REQ-038 Fill cid3 to CQ_DEPTH=16 entries -> rdy=0 for cid3 only; cid4 issue accepted.
REQ-039 ERR_EN defined: B bid=6 with NUM_CLIENT=5 -> wr_rsp_err=1, os_beat_cnt unchanged; undefined -> wr_rsp_err stays 0.
REQ-040 Reset asserted with 5 outstanding entries -> all outputs zero, no complete pulse; post-reset issue accepted.
